e203_itcm_boot_loader: RTL

//  Synthesizable ITCM preload controller for the E203 SoC sim/FPGA top. Takes a byte stream
//  (UART/JTAG-DPI/host bridge), packs bytes little-endian into 64-bit ITCM words, and writes

---
 rtl/e203_itcm_ldr_pkg.sv | 26 ++
 rtl/e203_itcm_byte_packer.sv | 82 ++++++++
 rtl/e203_itcm_boot_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/e203_itcm_ldr_pkg.sv
// ---------------------------------------------------------------------------
// e203_itcm_ldr_pkg
// Shared constants and types for the E203 ITCM boot loader:
//   - default ITCM geometry (word width, byte lanes, depth/address width)
//   - loader FSM state codes
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package e203_itcm_ldr_pkg;

  // Default ITCM geometry: 8192 words of 64 bits (64 KB).
  localparam int unsigned E203_ITCM_RAM_DP = 8192;
  localparam int unsigned ITCM_AW          = $clog2(E203_ITCM_RAM_DP);
  localparam int unsigned ITCM_BE_W        = 8;
  localparam int unsigned ITCM_DW          = 8 * ITCM_BE_W;

  // Loader FSM state codes.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } ldr_state_e;

endpackage

// File: rtl/e203_itcm_byte_packer.sv
// ---------------------------------------------------------------------------
// e203_itcm_byte_packer
// Packs a byte stream little-endian into one ITCM word (byte 0 -> [7:0]).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr_i           clear lane counter, mask, data and last flag (wins over push)
//   push_i          accept byte_i into the current lane
//   byte_i          byte payload
//   last_i          byte_i is the final byte of the image
//   data_o          packed word, unfilled lanes are zero
//   mask_o          one bit per filled lane
//   word_done_o     comb: this push completes the word (last lane or last byte)
//   last_o          the word currently held contains the final image byte
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module e203_itcm_byte_packer
  import e203_itcm_ldr_pkg::*;
#(
  parameter int unsigned BE_W = ITCM_BE_W,
  parameter int unsigned DW   = 8 * BE_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            push_i,
  input  logic [7:0]      byte_i,
  input  logic            last_i,
  output logic [DW-1:0]   data_o,
  output logic [BE_W-1:0] mask_o,
  output logic            word_done_o,
  output logic            last_o
);

  localparam int unsigned LW = $clog2(BE_W);

  logic [LW-1:0]   lane_q, lane_d;
  logic [BE_W-1:0] mask_q, mask_d;
  logic [DW-1:0]   data_q, data_d;
  logic            last_q, last_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    lane_d = lane_q;
    mask_d = mask_q;
    data_d = data_q;
    last_d = last_q;
    if (clr_i) begin
      lane_d = '0;
      mask_d = '0;
      data_d = '0;
      last_d = 1'b0;
    end else if (push_i) begin
      data_d[{lane_q, 3'b000} +: 8] = byte_i;
      mask_d[lane_q]                = 1'b1;
      lane_d                        = lane_q + LW'(1);
      last_d                        = last_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of evaluation order.
    if (!rst_n) begin
      lane_q <= '0;
      mask_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      mask_q <= mask_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign word_done_o = push_i & (last_i | (lane_q == LW'(BE_W - 1)));
  assign data_o      = data_q;
  assign mask_o      = mask_q;
  assign last_o      = last_q;

endmodule

// File: rtl/e203_itcm_boot_loader.sv
// ---------------------------------------------------------------------------
// e203_itcm_boot_loader
// ITCM preload controller: packs an incoming byte stream into ITCM words,
// writes them through a dedicated port while the core is held in reset, then
// hands the ITCM back and releases core reset after RST_HOLD cycles.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start_i                     begin a load at word 0 (IDLE/DONE/ERR only)
//   s_valid_i/s_ready_o/s_data_i/s_last_i   byte stream handshake
//   itcm_sel_o                  1: loader owns the ITCM port
//   itcm_cs_o/we_o/wem_o/addr_o/wdata_o     ITCM write port (1-cycle strobe)
//   core_rst_n_o                core reset, active-low
//   busy_o, done_o, err_o       status levels
//   words_o                     words written in current/last load
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module e203_itcm_boot_loader
  import e203_itcm_ldr_pkg::*;
#(
  parameter int unsigned DW       = ITCM_DW,
  parameter int unsigned BE_W     = ITCM_BE_W,
  parameter int unsigned AW       = ITCM_AW,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            s_valid_i,
  output logic            s_ready_o,
  input  logic [7:0]      s_data_i,
  input  logic            s_last_i,
  output logic            itcm_sel_o,
  output logic            itcm_cs_o,
  output logic            itcm_we_o,
  output logic [BE_W-1:0] itcm_wem_o,
  output logic [AW-1:0]   itcm_addr_o,
  output logic [DW-1:0]   itcm_wdata_o,
  output logic            core_rst_n_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [AW:0]     words_o
);

  localparam int unsigned HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [AW:0] WORDS_MAX = {1'b1, {AW{1'b0}}};

  ldr_state_e      state_q, state_d;
  logic [AW-1:0]   word_ptr_q, word_ptr_d;
  logic [AW:0]     words_q, words_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic            start_ok;
  logic            accept;
  logic            pk_clr;
  logic [DW-1:0]   pk_data;
  logic [BE_W-1:0] pk_mask;
  logic            pk_word_done;
  logic            pk_last;

  // Start is only honoured while no load is in flight.
  assign start_ok = start_i &
                    ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));
  assign accept   = s_valid_i & s_ready_o;
  assign pk_clr   = start_ok | (state_q == ST_WRITE);

  e203_itcm_byte_packer #(
    .BE_W (BE_W),
    .DW   (DW)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (pk_clr),
    .push_i      (accept),
    .byte_i      (s_data_i),
    .last_i      (s_last_i),
    .data_o      (pk_data),
    .mask_o      (pk_mask),
    .word_done_o (pk_word_done),
    .last_o      (pk_last)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_ptr_q <= '0;
      words_q    <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_ptr_q <= word_ptr_d;
      words_q    <= words_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state logic. A full non-last word at the top address ends in ERR;
  // the last word always goes to HOLD, even at the top address.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start_i) state_d = ST_LOAD;
      ST_LOAD:                  if (pk_word_done) state_d = ST_WRITE;
      ST_WRITE: begin
        if (pk_last)          state_d = ST_HOLD;
        else if (&word_ptr_q) state_d = ST_ERR;
        else                  state_d = ST_LOAD;
      end
      ST_HOLD:                  if (hold_q == '0) state_d = ST_DONE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Address, word count and hold counter. HOLD lasts exactly RST_HOLD cycles,
  // so core reset rises RST_HOLD cycles after the final WRITE cycle ends.
  always_comb begin
    word_ptr_d = word_ptr_q;
    words_d    = words_q;
    hold_d     = hold_q;
    if (start_ok) begin
      word_ptr_d = '0;
      words_d    = '0;
    end
    if (state_q == ST_WRITE) begin
      word_ptr_d = word_ptr_q + AW'(1);
      if (words_q != WORDS_MAX) words_d = words_q + (AW+1)'(1);
      hold_d = HW'(RST_HOLD - 1);
    end
    if ((state_q == ST_HOLD) && (hold_q != '0)) hold_d = hold_q - HW'(1);
  end

  // State-decoded outputs.
  always_comb begin
    s_ready_o    = 1'b0;
    itcm_sel_o   = 1'b1;
    itcm_cs_o    = 1'b0;
    core_rst_n_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        s_ready_o = 1'b1;
        busy_o    = 1'b1;
      end
      ST_WRITE: begin
        itcm_cs_o = 1'b1;
        busy_o    = 1'b1;
      end
      ST_HOLD: begin
        itcm_sel_o = 1'b0;
        busy_o     = 1'b1;
      end
      ST_DONE: begin
        itcm_sel_o   = 1'b0;
        core_rst_n_o = 1'b1;
        done_o       = 1'b1;
      end
      ST_ERR:  err_o = 1'b1;
      default: ;
    endcase
  end

  // Write payload is only driven during the write strobe, zero otherwise.
  assign itcm_we_o    = itcm_cs_o;
  assign itcm_wem_o   = itcm_cs_o ? pk_mask    : '0;
  assign itcm_addr_o  = itcm_cs_o ? word_ptr_q : '0;
  assign itcm_wdata_o = itcm_cs_o ? pk_data    : '0;
  assign words_o      = words_q;

endmodule
